axis_cnt_chk: RTL and testbench
===============================

Name: axis_cnt_chk

Overview:
- AXI-Stream sink and checker for the counter-pattern stream made by the team's counter source.
- Accepts beats carrying TDATA_QTY replicated copies of a wrapping counter, plus tuser and tlast, and checks every field against an internally regenerated expected count.
- Drives tready with a selectable backpressure pattern so the source's stall handling is exercised.
- Reports beat, packet and error counts, a sticky error flag and the first offending data word.

Parameters:
TDATA_DW, 32, width of one counter lane.
TDATA_QTY, 2, number of replicated lanes in tdata.
TUSER_DW, 32, tuser width; must be <= TDATA_DW.
CNT_DW, 32, width of the status counters.

Ports:
s_axis_aclk  in  1  single clock for all logic.
s_axis_areset  in  1  synchronous reset, active-high.
chk_en_i  in  1  checker enable (level).
max_value_i  in  TDATA_DW  wrap threshold, same meaning as at the source.
bp_mode_i  in  2  tready pattern: 00 always, 01 alternate, 10 LFSR, 11 never.
s_axis_tdata  in  TDATA_QTY*TDATA_DW  replicated counter lanes; lane 0 = LSBs.
s_axis_tuser  in  TUSER_DW  counter LSBs.
s_axis_tlast  in  1  last-of-packet.
s_axis_tvalid  in  1  beat valid.
s_axis_tready  out  1  registered ready.
locked_o  out  1  checker synchronised to stream.
beat_cnt_o  out  CNT_DW  beats accepted while locked.
pkt_cnt_o  out  CNT_DW  accepted beats with tlast=1 while locked.
err_cnt_o  out  CNT_DW  erroneous beats, saturating.
err_o  out  1  sticky, set on first error.
first_err_data_o  out  TDATA_QTY*TDATA_DW  tdata of the first erroneous beat.

Behaviour:
- Reset:
  - All outputs 0; state ST_IDLE.
  - Expected count exp = 0; LFSR = 16'hACE1.
  - Reset mid-operation discards all status and returns to ST_IDLE on that edge.
- Acceptance:
  - A beat is accepted on a rising edge where s_axis_tvalid & s_axis_tready.
  - tready is a registered output and never depends combinationally on tvalid.
  - tvalid deasserting without acceptance is tolerated and not an error.
- Ready pattern, evaluated each cycle and registered:
  - tready = 0 in ST_IDLE.
  - Otherwise: mode 00 → 1; mode 01 → toggles every cycle starting at 1; mode 10 → lfsr[0]; mode 11 → 0.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle in mode 10 only.
  - A mode change takes effect on the next cycle.
- State machine:
  - ST_IDLE → ST_SYNC when chk_en_i = 1. On that transition, clear beat_cnt_o, pkt_cnt_o, err_cnt_o, err_o and first_err_data_o.
  - ST_SYNC (tready per pattern; beats are accepted and discarded) → ST_CHECK on the first accepted beat where every lane = 0. That beat is checked as exp = 0 and counted. locked_o rises with this transition.
  - ST_CHECK → ST_IDLE when chk_en_i = 0. This has priority over any beat accepted in the same cycle: that beat is not counted. Status holds its values in ST_IDLE. locked_o falls.
  - ST_SYNC → ST_IDLE when chk_en_i = 0.
- Check of an accepted beat in ST_CHECK (and of the locking beat):
  - The beat is erroneous if any of these holds:
    - any lane ≠ exp;
    - tuser ≠ exp[TUSER_DW-1:0];
    - tlast ≠ (exp+1 ≥ max_value_i), computed unsigned at TDATA_DW+1 bits so that exp = all-ones does not overflow.
  - Next exp:
    - Good beat: (exp+1 ≥ max_value_i) ? 0 : exp+1.
    - Erroneous beat: re-seed from the received lane 0 with the same wrap rule, so that one glitch costs exactly one error.
  - If max_value_i ≤ 1, exp stays 0 and every beat must carry tlast = 1.
- Counters:
  - beat_cnt_o and pkt_cnt_o wrap modulo 2^CNT_DW.
  - err_cnt_o saturates at all-ones.
  - All counters update on the accepting edge, so the new value is visible in the following cycle. Latency from acceptance to status = 1 cycle.
- Error capture:
  - err_o sets on the first error and stays set until the next ST_IDLE→ST_SYNC transition or reset.
  - first_err_data_o captures only on the first error.
- max_value_i may change at run time; the change applies from the next accepted beat.

Test Plan:
- Mode 00, max = 5, source streams 0,1,2,3,4,0,… for 20 beats → locked_o = 1 after the first 0; beat_cnt_o = 20, pkt_cnt_o = 4 (tlast on value 4), err_cnt_o = 0, err_o = 0.
- Mode 01, max = 8, 16 beats → tready alternates 1,0,1,0; source holds data while stalled; beat_cnt_o = 16, pkt_cnt_o = 2, no errors.
- Mode 10, 1000 beats with max = 100 → tready follows lfsr[0] from seed ACE1; counts match the reference model; err_cnt_o = 0.
- Lane corruption: beat 3 has lane 1 = 0x99 with lane 0 = 3 → err_cnt_o = 1, err_o = 1, first_err_data_o = {0x99, 0x3}; stream continues with no further errors.
- Skip: source jumps 2 → 5 with max = 10 → exactly 1 error; beats 6,7,… check clean after the re-seed.
- Start mid-stream at value 7, then wrap, with max = 10 → beats 7,8,9 discarded in ST_SYNC; lock on 0; beat_cnt_o starts at 1.
- Assert s_axis_areset while locked with err_o = 1 → next cycle all outputs 0, tready = 0, ST_IDLE.
- max = 1 → every beat is 0 with tlast = 1; a beat with tlast = 0 → err_cnt_o increments.

Source files
------------

// File: rtl/axis_cnt_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_cnt_chk                                                 |
// | Description : AXI-Stream sink that locks onto a replicated wrapping        |
// |               counter stream and checks every lane, tuser and tlast.       |
// |               It drives tready with a selectable backpressure pattern and  |
// |               reports beat, packet and error counts.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axis_cnt_chk #(
  parameter int TDATA_DW  = 32,
  parameter int TDATA_QTY = 2,
  parameter int TUSER_DW  = 32,
  parameter int CNT_DW    = 32
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_areset,
  input  logic                          chk_en_i,
  input  logic [TDATA_DW-1:0]           max_value_i,
  input  logic [1:0]                    bp_mode_i,
  input  logic [TDATA_QTY*TDATA_DW-1:0] s_axis_tdata,
  input  logic [TUSER_DW-1:0]           s_axis_tuser,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic                          locked_o,
  output logic [CNT_DW-1:0]             beat_cnt_o,
  output logic [CNT_DW-1:0]             pkt_cnt_o,
  output logic [CNT_DW-1:0]             err_cnt_o,
  output logic                          err_o,
  output logic [TDATA_QTY*TDATA_DW-1:0] first_err_data_o
);

  localparam int          c_DW         = TDATA_QTY * TDATA_DW;
  localparam logic [1:0]  c_ST_IDLE    = 2'd0;
  localparam logic [1:0]  c_ST_SYNC    = 2'd1;
  localparam logic [1:0]  c_ST_CHECK   = 2'd2;
  localparam logic [1:0]  c_BP_ALWAYS  = 2'b00;
  localparam logic [1:0]  c_BP_ALT     = 2'b01;
  localparam logic [1:0]  c_BP_LFSR    = 2'b10;
  localparam logic [15:0] c_LFSR_SEED  = 16'hACE1;
  localparam logic [TDATA_DW:0] c_ONE_X  = {{TDATA_DW{1'b0}}, 1'b1};
  localparam logic [CNT_DW-1:0] c_ONE_C  = {{(CNT_DW-1){1'b0}}, 1'b1};

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_tready;
  logic                r_alt;
  logic [15:0]         r_lfsr;
  logic [TDATA_DW-1:0] r_exp;
  logic [CNT_DW-1:0]   r_beat_cnt;
  logic [CNT_DW-1:0]   r_pkt_cnt;
  logic [CNT_DW-1:0]   r_err_cnt;
  logic                r_err;
  logic [c_DW-1:0]     r_first_err;

  logic                w_acc;
  logic                w_pat;
  logic                w_locked;
  logic                w_clr;
  logic                w_chk;
  logic                w_bad;
  logic                w_wrap;
  logic                w_seed_wrap;
  logic [TDATA_DW:0]   w_exp_p1;
  logic [TDATA_DW:0]   w_seed_p1;
  logic [TDATA_DW-1:0] w_exp_nxt;
  logic [TDATA_QTY-1:0] w_lane_mis;
  logic [TDATA_QTY-1:0] w_lane_zero;

  // Per-lane comparison against the expected count and against zero (lock).
  for (genvar g = 0; g < TDATA_QTY; g++) begin : g_lane
    assign w_lane_mis[g]  = (s_axis_tdata[g*TDATA_DW +: TDATA_DW] != r_exp);
    assign w_lane_zero[g] = (s_axis_tdata[g*TDATA_DW +: TDATA_DW] == '0);
  end

  assign w_acc = s_axis_tvalid & r_tready;

  // Expected-count arithmetic one bit wider so an all-ones count cannot wrap.
  always_comb begin
    w_exp_p1    = {1'b0, r_exp} + c_ONE_X;
    w_seed_p1   = {1'b0, s_axis_tdata[TDATA_DW-1:0]} + c_ONE_X;
    w_wrap      = (w_exp_p1 >= {1'b0, max_value_i});
    w_seed_wrap = (w_seed_p1 >= {1'b0, max_value_i});
    w_bad       = (|w_lane_mis) ||
                  (s_axis_tuser != r_exp[TUSER_DW-1:0]) ||
                  (s_axis_tlast != w_wrap);
    if (w_bad) begin
      // Re-seed from the received count so a single glitch costs one error.
      w_exp_nxt = w_seed_wrap ? '0 : w_seed_p1[TDATA_DW-1:0];
    end else begin
      w_exp_nxt = w_wrap ? '0 : w_exp_p1[TDATA_DW-1:0];
    end
  end

  // State register.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) r_state <= c_ST_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Next-state logic; dropping the enable wins over a beat in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (chk_en_i) w_state_nxt = c_ST_SYNC;
      c_ST_SYNC: begin
        if (!chk_en_i)                        w_state_nxt = c_ST_IDLE;
        else if (w_acc && (&w_lane_zero))     w_state_nxt = c_ST_CHECK;
      end
      c_ST_CHECK: if (!chk_en_i) w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // FSM-derived controls: lock flag, status clear and beat-check strobe.
  always_comb begin
    w_locked = (r_state == c_ST_CHECK);
    w_clr    = (r_state == c_ST_IDLE) && chk_en_i;
    w_chk    = w_acc && chk_en_i &&
               ((r_state == c_ST_CHECK) || ((r_state == c_ST_SYNC) && (&w_lane_zero)));
  end

  // Backpressure pattern selected for the coming cycle.
  always_comb begin
    case (bp_mode_i)
      c_BP_ALWAYS: w_pat = 1'b1;
      c_BP_ALT:    w_pat = r_alt;
      c_BP_LFSR:   w_pat = r_lfsr[0];
      default:     w_pat = 1'b0;
    endcase
  end

  // Registered tready plus the alternate-phase and LFSR pattern generators.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_tready <= 1'b0;
      r_alt    <= 1'b1;
      r_lfsr   <= c_LFSR_SEED;
    end else begin
      r_tready <= (w_state_nxt != c_ST_IDLE) && w_pat;
      r_alt    <= ((w_state_nxt != c_ST_IDLE) && (bp_mode_i == c_BP_ALT)) ? ~r_alt : 1'b1;
      if (bp_mode_i == c_BP_LFSR)
        r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    end
  end

  // Expected count and status counters, updated on each checked beat.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset || w_clr) begin
      r_exp       <= '0;
      r_beat_cnt  <= '0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_err       <= 1'b0;
      r_first_err <= '0;
    end else if (w_chk) begin
      r_exp      <= w_exp_nxt;
      r_beat_cnt <= r_beat_cnt + c_ONE_C;
      if (s_axis_tlast) r_pkt_cnt <= r_pkt_cnt + c_ONE_C;
      if (w_bad) begin
        if (r_err_cnt != {CNT_DW{1'b1}}) r_err_cnt <= r_err_cnt + c_ONE_C;
        if (!r_err) begin
          r_err       <= 1'b1;
          r_first_err <= s_axis_tdata;
        end
      end
    end
  end

  assign s_axis_tready    = r_tready;
  assign locked_o         = w_locked;
  assign beat_cnt_o       = r_beat_cnt;
  assign pkt_cnt_o        = r_pkt_cnt;
  assign err_cnt_o        = r_err_cnt;
  assign err_o            = r_err;
  assign first_err_data_o = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_axis_cnt_chk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_cnt_chk                                              |
// | Description : Directed bench for axis_cnt_chk with a reference model and   |
// |               a per-cycle scoreboard of expected status.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axis_cnt_chk;

  localparam int TDATA_DW  = 32;
  localparam int TDATA_QTY = 2;
  localparam int TUSER_DW  = 32;
  localparam int CNT_DW    = 8;

  logic        clk = 1'b0;
  logic        s_axis_areset;
  logic        chk_en;
  logic [31:0] max_value;
  logic [1:0]  bp_mode;
  logic [63:0] s_axis_tdata;
  logic [31:0] s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        locked;
  logic [7:0]  beat_cnt, pkt_cnt, err_cnt;
  logic        err;
  logic [63:0] first_err_data;

  typedef struct packed {
    logic [7:0]  beat;
    logic [7:0]  pkt;
    logic [7:0]  errc;
    logic        errf;
    logic        lock;
    logic [63:0] first;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_active, m_locked, m_errf, acc, lfsr_chk, exp_rdy;
  logic [31:0] m_exp;
  logic [7:0]  m_beat, m_pkt, m_err;
  logic [63:0] m_first;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  axis_cnt_chk #(
    .TDATA_DW (TDATA_DW),
    .TDATA_QTY(TDATA_QTY),
    .TUSER_DW (TUSER_DW),
    .CNT_DW   (CNT_DW)
  ) dut (
    .s_axis_aclk     (clk),
    .s_axis_areset   (s_axis_areset),
    .chk_en_i        (chk_en),
    .max_value_i     (max_value),
    .bp_mode_i       (bp_mode),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .locked_o        (locked),
    .beat_cnt_o      (beat_cnt),
    .pkt_cnt_o       (pkt_cnt),
    .err_cnt_o       (err_cnt),
    .err_o           (err),
    .first_err_data_o(first_err_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_exp = '0; m_beat = '0; m_pkt = '0; m_err = '0; m_errf = 1'b0; m_first = '0;
  endtask

  // Reference behaviour for one accepted beat while enabled.
  task automatic model_accept();
    logic [31:0] l0, l1;
    logic [32:0] p1, base;
    logic        bad;
    l0 = s_axis_tdata[31:0];
    l1 = s_axis_tdata[63:32];
    if (!m_locked) begin
      if (l0 != 0 || l1 != 0) return;
      m_locked = 1'b1;
      m_exp    = '0;
    end
    p1  = {1'b0, m_exp} + 33'd1;
    bad = (l0 != m_exp) || (l1 != m_exp) || (s_axis_tuser != m_exp) ||
          (s_axis_tlast != (p1 >= {1'b0, max_value}));
    m_beat = m_beat + 8'd1;
    if (s_axis_tlast) m_pkt = m_pkt + 8'd1;
    if (bad) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      if (!m_errf) begin m_errf = 1'b1; m_first = s_axis_tdata; end
      base = {1'b0, l0} + 33'd1;
    end else begin
      base = p1;
    end
    m_exp = (base >= {1'b0, max_value}) ? 32'd0 : base[31:0];
  endtask

  // One clock: sample tready, update the model at the edge, compare status after it.
  task automatic cycle();
    logic rdy;
    exp_t e;
    @(negedge clk);
    rdy = s_axis_tready;
    if (lfsr_chk) chk("tready_lfsr", rdy, exp_rdy);
    @(posedge clk);
    acc = s_axis_tvalid && rdy;
    if (bp_mode == 2'b10) begin
      exp_rdy = chk_en ? m_lfsr[0] : 1'b0;
      m_lfsr  = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
    if (!chk_en) begin
      m_active = 1'b0; m_locked = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1; m_locked = 1'b0; model_clear();
    end else if (acc) begin
      model_accept();
    end
    sb_q.push_back('{beat: m_beat, pkt: m_pkt, errc: m_err, errf: m_errf, lock: m_locked, first: m_first});
    #1;
    e = sb_q.pop_front();
    chk("beat_cnt", beat_cnt, e.beat);
    chk("pkt_cnt", pkt_cnt, e.pkt);
    chk("err_cnt", err_cnt, e.errc);
    chk("err_o", err, e.errf);
    chk("locked", locked, e.lock);
    chk("first_err", first_err_data, e.first);
  endtask

  task automatic send_beat(input logic [31:0] l0, input logic [31:0] l1,
                           input logic [31:0] u, input logic last);
    int n;
    s_axis_tdata  = {l1, l0};
    s_axis_tuser  = u;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc && n < 100);
    chk("accept", acc, 1'b1);
  endtask

  task automatic stream(input int n, input logic [31:0] start, input logic [31:0] mx);
    logic [32:0] nx;
    logic [31:0] v;
    max_value = mx;
    v = start;
    for (int i = 0; i < n; i++) begin
      nx = {1'b0, v} + 33'd1;
      send_beat(v, v, v, nx >= {1'b0, mx});
      v = (nx >= {1'b0, mx}) ? 32'd0 : nx[31:0];
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    s_axis_areset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_beat", beat_cnt, 8'd0);
    chk("rst_pkt", pkt_cnt, 8'd0);
    chk("rst_errc", err_cnt, 8'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_first", first_err_data, 64'd0);
    model_clear();
    m_active = 1'b0; m_locked = 1'b0; m_lfsr = 16'hACE1; exp_rdy = 1'b0;
    s_axis_areset = 1'b0;
  endtask

  task automatic restart();
    s_axis_tvalid = 1'b0;
    chk_en = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
  endtask

  initial begin
    logic [7:0] saved;
    s_axis_areset = 1'b1; chk_en = 1'b0; max_value = 32'd5; bp_mode = 2'b00;
    s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    lfsr_chk = 1'b0; exp_rdy = 1'b0; acc = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Always-ready, max 5, 20 beats.
    chk_en = 1'b1;
    cycle();
    stream(20, 0, 5);
    chk("t1_beat", beat_cnt, 8'd20);
    chk("t1_pkt", pkt_cnt, 8'd4);
    chk("t1_err", err_cnt, 8'd0);
    chk("t1_locked", locked, 1'b1);

    // Alternating ready, max 8, 16 beats.
    bp_mode = 2'b01;
    restart();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_alt", s_axis_tready, (i % 2 == 0) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
    end
    stream(16, 0, 8);
    chk("t2_beat", beat_cnt, 8'd16);
    chk("t2_pkt", pkt_cnt, 8'd2);
    chk("t2_err", err_cnt, 8'd0);

    // LFSR ready from seed, max 100, 1000 beats.
    do_reset();
    bp_mode  = 2'b10;
    chk_en   = 1'b1;
    lfsr_chk = 1'b1;
    stream(1000, 0, 100);
    lfsr_chk = 1'b0;
    chk("t3_beat", beat_cnt, 8'd232);
    chk("t3_pkt", pkt_cnt, 8'd10);
    chk("t3_err", err_cnt, 8'd0);

    // Lane corruption on beat 3.
    bp_mode = 2'b00;
    restart();
    stream(3, 0, 10);
    send_beat(32'd3, 32'h99, 32'd3, 1'b0);
    stream(10, 4, 10);
    chk("t4_err", err_cnt, 8'd1);
    chk("t4_errf", err, 1'b1);
    chk("t4_first", first_err_data, {32'h99, 32'h3});

    // Skip 2 -> 5.
    restart();
    stream(3, 0, 10);
    stream(8, 5, 10);
    chk("t5_err", err_cnt, 8'd1);
    chk("t5_beat", beat_cnt, 8'd11);

    // Reset while locked with a sticky error.
    chk("t7_pre_err", err, 1'b1);
    do_reset();

    // Start mid-stream at 7.
    chk_en = 1'b1;
    cycle();
    stream(3, 7, 10);
    chk("t6_unlocked", locked, 1'b0);
    chk("t6_beat0", beat_cnt, 8'd0);
    stream(1, 0, 10);
    chk("t6_locked", locked, 1'b1);
    chk("t6_beat1", beat_cnt, 8'd1);
    stream(5, 1, 10);
    chk("t6_err", err_cnt, 8'd0);

    // max = 1: every beat is 0 with tlast set.
    restart();
    stream(3, 0, 1);
    chk("t8_clean", err_cnt, 8'd0);
    chk("t8_pkt", pkt_cnt, 8'd3);
    send_beat(32'd0, 32'd0, 32'd0, 1'b0);
    s_axis_tvalid = 1'b0;
    chk("t8_err", err_cnt, 8'd1);

    // Disable in the same cycle as an accepted beat: beat is not counted.
    saved = m_beat;
    s_axis_tdata = '0; s_axis_tuser = '0; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    chk_en = 1'b0;
    cycle();
    s_axis_tvalid = 1'b0;
    chk("t9_beat_hold", beat_cnt, saved);
    chk("t9_unlocked", locked, 1'b0);

    // Error counter saturation.
    chk_en = 1'b1;
    cycle();
    stream(1, 0, 10);
    for (int i = 0; i < 260; i++) send_beat(32'd0, 32'd5, 32'd0, 1'b0);
    s_axis_tvalid = 1'b0;
    chk("t10_sat", err_cnt, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
